qam_mod_ctrl: RTL and testbench
===============================

Name: qam_mod_ctrl

Overview:
Symbol-timing and framing controller in front of the QAM mapper/modulator datapath, running on the 11.0592 MHz system clock.
- Shadows the run-time configuration (modulation type, baud rate, filter enable, carrier frequency) and applies it only between bursts.
- Generates the baud-rate symbol strobe.
- Accepts bytes over a valid/ready handshake and slices them MSB-first into 2-bit (QPSK) or 4-bit (16QAM) symbols.
- Ends a burst after a run of consecutive underruns.

Parameters:
BASE_DIV, 1152, clock cycles per symbol at 9600 baud (11059200/9600).
IDLE_TICKS, 4, consecutive underrun ticks before returning to IDLE (1..15).
CNT_W, 14, baud counter width; must hold BASE_DIV*8-1.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
mod_type  in  1  0=QPSK (2 bits/sym), 1=16QAM (4 bits/sym).
baud_rate  in  2  00=1200, 01=2400, 10=4800, 11=9600.
filter_enable  in  1  shaping filter enable request.
carrier_freq_set  in  16  carrier frequency request, Hz.
cfg_load  in  1  one-cycle pulse: capture the four config inputs.
in_data  in  8  payload byte.
in_valid  in  1  byte valid.
in_ready  out  1  byte accepted when in_valid&&in_ready.
sym_data  out  4  symbol, MSB-first slice; QPSK uses [1:0], [3:2]=0.
sym_valid  out  1  one-cycle strobe per baud tick in RUN.
sym_fill  out  1  qualifies sym_valid: underrun fill symbol (sym_data=0).
act_mod_type  out  1  active modulation type.
act_baud  out  2  active baud code.
act_filter  out  1  active filter enable.
act_freq  out  16  active carrier frequency.
busy  out  1  1 in RUN.
cfg_pending  out  1  cfg_load captured during RUN, not yet applied.

Behaviour:
Reset values:
- in_ready=1.
- sym_data=0, sym_valid=0, sym_fill=0, busy=0, cfg_pending=0.
- act_mod_type=0, act_baud=2'b11, act_filter=0, act_freq=0.
- State IDLE; shift register, hold register and counters cleared.
- Reset mid-burst discards all buffered bits; no further sym_valid is issued.

Baud divider:
- div = BASE_DIV << (3 - act_baud), giving 9216/4608/2304/1152 cycles.
- In IDLE the counter is held at div-1.
- In RUN it counts 0..div-1 and wraps; tick is asserted when counter == div-1.

Buffering:
- Hold register (1 byte, hold_valid); in_ready = !hold_valid, registered.
- Shift register: 8 bits plus shift_cnt (0..8 bits remaining).
- Bits per symbol: bps = act_mod_type ? 4 : 2.

Data path on tick:
- If shift_cnt != 0: emit shift[7:8-bps]; shift <<= bps; shift_cnt -= bps.
- Else if hold_valid: emit hold[7:8-bps]; shift <= hold<<bps; shift_cnt <= 8-bps; hold_valid <= 0. A byte therefore streams gap-free behind its predecessor.
- Else (underrun): emit sym_data=0, sym_fill=1; increment under_cnt.
- Any real symbol clears under_cnt.
- A handshake can never coincide with hold consumption, because in_ready=0 while hold_valid=1.

Output timing:
- sym_data, sym_valid and sym_fill are registered.
- sym_valid asserts the cycle after the tick, for one cycle.

State machine:
- IDLE:
  - On handshake at cycle t: go to RUN at t+1 with hold_valid=1.
  - First tick occurs at t+1, so the first sym_valid is at t+2; subsequent sym_valid every div cycles.
- RUN:
  - When under_cnt reaches IDLE_TICKS on a tick: go to IDLE the next cycle and clear under_cnt.
  - The IDLE_TICKS-th fill symbol is still emitted.
- Entering IDLE with cfg_pending=1: act_* are loaded from the current config inputs; cfg_pending is cleared.

Config:
- cfg_load in IDLE: act_* are updated the next cycle.
- cfg_load in RUN: sets cfg_pending only; act_* stay frozen for the whole burst.
- cfg_load in IDLE in the same cycle as a byte handshake: the config is applied first and the burst uses the new config.

Test Plan:
1. After rst: cfg_load with mod_type=1, baud_rate=11; send byte 0xA5 at cycle t -> sym_valid at t+2 with sym_data=0xA; sym_valid at t+2+1152 with sym_data=0x5; no fill.
2. Same stimulus with mod_type=0, baud_rate=00, byte 0xB4 -> symbols 2,3,1,0 spaced 9216 cycles; then 4 fill symbols (sym_fill=1, data 0); busy falls one cycle after the 4th fill tick.
3. Back-to-back 16QAM bytes 0x12, 0x34, 0x56 with in_valid held high -> symbols 1,2,3,4,5,6 at exactly 1152-cycle spacing; in_ready low while hold is full; zero fill symbols.
4. cfg_load during RUN with mod_type=0, carrier_freq_set=16'd50000 -> act_* unchanged and cfg_pending=1 until IDLE; in the first IDLE cycle act_freq=50000, act_mod_type=0, cfg_pending=0.
5. Underrun recovery: a second byte arriving after 2 fill ticks -> under_cnt clears; burst continues with no return to IDLE.
6. rst asserted midway through byte 0xA5 -> the next cycle shows all outputs at reset values; no further sym_valid; in_ready=1.

Source files
------------

// File: rtl/qam_mod_ctrl.sv
// Symbol-timing and framing controller ahead of the QAM mapper: shadows config,
// generates the baud strobe and slices handshaked bytes MSB-first into symbols.
module qam_mod_ctrl #(
   parameter int BASE_DIV   = 1152,
   parameter int IDLE_TICKS = 4,
   parameter int CNT_W      = 14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mod_type,
   input  logic [1:0]  baud_rate,
   input  logic        filter_enable,
   input  logic [15:0] carrier_freq_set,
   input  logic        cfg_load,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [3:0]  sym_data,
   output logic        sym_valid,
   output logic        sym_fill,
   output logic        act_mod_type,
   output logic [1:0]  act_baud,
   output logic        act_filter,
   output logic [15:0] act_freq,
   output logic        busy,
   output logic        cfg_pending
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Last count value of the divider for a given baud code (9600 baud = code 3).
   function automatic logic [CNT_W-1:0] div_last(input logic [1:0] baud);
      logic [CNT_W-1:0] base;
      base     = CNT_W'(BASE_DIV);
      div_last = (base << (2'd3 - baud)) - CNT_W'(1);
   endfunction

   function automatic logic [3:0] slice_top(input logic [7:0] b, input logic qam16);
      slice_top = qam16 ? b[7:4] : {2'b00, b[7:6]};
   endfunction

   function automatic logic [7:0] shift_up(input logic [7:0] b, input logic qam16);
      shift_up = qam16 ? {b[3:0], 4'h0} : {b[5:0], 2'b00};
   endfunction

   logic [0:0]       state_r, state_nxt;
   logic [CNT_W-1:0] baud_cnt_r, baud_cnt_nxt;
   logic [7:0]       hold_r, hold_nxt, shift_r, shift_nxt;
   logic             hold_valid_r, hold_valid_nxt;
   logic [3:0]       shift_cnt_r, shift_cnt_nxt;
   logic [3:0]       under_cnt_r, under_cnt_nxt;
   logic             in_ready_r, in_ready_nxt;
   logic [3:0]       sym_data_r, sym_data_nxt;
   logic             sym_valid_r, sym_valid_nxt;
   logic             sym_fill_r, sym_fill_nxt;
   logic             busy_r, busy_nxt;
   logic             cfg_pending_r, cfg_pending_nxt;
   logic             act_mod_type_r, act_mod_type_nxt;
   logic [1:0]       act_baud_r, act_baud_nxt;
   logic             act_filter_r, act_filter_nxt;
   logic [15:0]      act_freq_r, act_freq_nxt;
   logic             accept_s, tick_s, load_cfg_s, go_idle_s;
   logic [3:0]       bps_s;

   // Next-state logic for the datapath, framing FSM, config shadow and divider.
   always_comb begin
      state_nxt        = state_r;
      hold_nxt         = hold_r;
      hold_valid_nxt   = hold_valid_r;
      shift_nxt        = shift_r;
      shift_cnt_nxt    = shift_cnt_r;
      under_cnt_nxt    = under_cnt_r;
      cfg_pending_nxt  = cfg_pending_r;
      act_mod_type_nxt = act_mod_type_r;
      act_baud_nxt     = act_baud_r;
      act_filter_nxt   = act_filter_r;
      act_freq_nxt     = act_freq_r;
      sym_data_nxt     = 4'd0;
      sym_fill_nxt     = 1'b0;
      load_cfg_s       = 1'b0;
      go_idle_s        = 1'b0;

      accept_s      = in_valid && in_ready_r;
      tick_s        = (state_r == ST_RUN) && (baud_cnt_r == div_last(act_baud_r));
      bps_s         = act_mod_type_r ? 4'd4 : 4'd2;
      sym_valid_nxt = tick_s;

      if (tick_s) begin
         if (shift_cnt_r != 4'd0) begin
            sym_data_nxt  = slice_top(shift_r, act_mod_type_r);
            shift_nxt     = shift_up(shift_r, act_mod_type_r);
            shift_cnt_nxt = shift_cnt_r - bps_s;
            under_cnt_nxt = 4'd0;
         end else if (hold_valid_r) begin
            sym_data_nxt   = slice_top(hold_r, act_mod_type_r);
            shift_nxt      = shift_up(hold_r, act_mod_type_r);
            shift_cnt_nxt  = 4'd8 - bps_s;
            hold_valid_nxt = 1'b0;
            under_cnt_nxt  = 4'd0;
         end else begin
            sym_fill_nxt  = 1'b1;
            under_cnt_nxt = under_cnt_r + 4'd1;
         end
      end else begin
         under_cnt_nxt = under_cnt_r;
      end

      // in_ready mirrors !hold_valid, so acceptance never races hold consumption.
      if (accept_s) begin
         hold_nxt       = in_data;
         hold_valid_nxt = 1'b1;
      end else begin
         hold_nxt = hold_r;
      end

      case (state_r)
         ST_IDLE: begin
            under_cnt_nxt   = 4'd0;
            cfg_pending_nxt = 1'b0;
            load_cfg_s      = cfg_load;
            if (accept_s) begin
               state_nxt = ST_RUN;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            // A byte landing on the terminating tick keeps the burst alive.
            go_idle_s = tick_s && sym_fill_nxt && !accept_s &&
                        (under_cnt_nxt == 4'(IDLE_TICKS));
            if (go_idle_s) begin
               state_nxt       = ST_IDLE;
               under_cnt_nxt   = 4'd0;
               load_cfg_s      = cfg_pending_r || cfg_load;
               cfg_pending_nxt = 1'b0;
            end else if (cfg_load) begin
               cfg_pending_nxt = 1'b1;
            end else begin
               cfg_pending_nxt = cfg_pending_r;
            end
         end
         default: begin
            state_nxt     = ST_IDLE;
            under_cnt_nxt = 4'd0;
         end
      endcase

      if (load_cfg_s) begin
         act_mod_type_nxt = mod_type;
         act_baud_nxt     = baud_rate;
         act_filter_nxt   = filter_enable;
         act_freq_nxt     = carrier_freq_set;
      end else begin
         act_freq_nxt = act_freq_r;
      end

      in_ready_nxt = !hold_valid_nxt;
      busy_nxt     = (state_nxt == ST_RUN);

      // Parking at div-1 in IDLE makes the first RUN cycle a tick.
      if (state_r != ST_RUN) begin
         baud_cnt_nxt = div_last(act_baud_nxt);
      end else if (tick_s) begin
         baud_cnt_nxt = {CNT_W{1'b0}};
      end else begin
         baud_cnt_nxt = baud_cnt_r + CNT_W'(1);
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         baud_cnt_r     <= {CNT_W{1'b0}};
         hold_r         <= 8'd0;
         hold_valid_r   <= 1'b0;
         shift_r        <= 8'd0;
         shift_cnt_r    <= 4'd0;
         under_cnt_r    <= 4'd0;
         in_ready_r     <= 1'b1;
         sym_data_r     <= 4'd0;
         sym_valid_r    <= 1'b0;
         sym_fill_r     <= 1'b0;
         busy_r         <= 1'b0;
         cfg_pending_r  <= 1'b0;
         act_mod_type_r <= 1'b0;
         act_baud_r     <= 2'b11;
         act_filter_r   <= 1'b0;
         act_freq_r     <= 16'd0;
      end else begin
         state_r        <= state_nxt;
         baud_cnt_r     <= baud_cnt_nxt;
         hold_r         <= hold_nxt;
         hold_valid_r   <= hold_valid_nxt;
         shift_r        <= shift_nxt;
         shift_cnt_r    <= shift_cnt_nxt;
         under_cnt_r    <= under_cnt_nxt;
         in_ready_r     <= in_ready_nxt;
         sym_data_r     <= sym_data_nxt;
         sym_valid_r    <= sym_valid_nxt;
         sym_fill_r     <= sym_fill_nxt;
         busy_r         <= busy_nxt;
         cfg_pending_r  <= cfg_pending_nxt;
         act_mod_type_r <= act_mod_type_nxt;
         act_baud_r     <= act_baud_nxt;
         act_filter_r   <= act_filter_nxt;
         act_freq_r     <= act_freq_nxt;
      end
   end

   assign in_ready     = in_ready_r;
   assign sym_data     = sym_data_r;
   assign sym_valid    = sym_valid_r;
   assign sym_fill     = sym_fill_r;
   assign busy         = busy_r;
   assign cfg_pending  = cfg_pending_r;
   assign act_mod_type = act_mod_type_r;
   assign act_baud     = act_baud_r;
   assign act_filter   = act_filter_r;
   assign act_freq     = act_freq_r;

endmodule

// File: tb/tb_qam_mod_ctrl.sv
// Directed bench for qam_mod_ctrl: expected symbols (value, fill flag, cycle)
// are queued as bytes are sent and checked as sym_valid strobes appear.
module tb_qam_mod_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mod_type;
   logic [1:0]  baud_rate;
   logic        filter_enable;
   logic [15:0] carrier_freq_set;
   logic        cfg_load;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  sym_data;
   logic        sym_valid;
   logic        sym_fill;
   logic        act_mod_type;
   logic [1:0]  act_baud;
   logic        act_filter;
   logic [15:0] act_freq;
   logic        busy;
   logic        cfg_pending;

   typedef struct {
      logic [3:0] data;
      logic       fill;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   nxt = 0;
   int   last_cyc = 0;
   int   div = 1152;
   int   passed = 0;
   int   fails = 0;
   int   total = 0;
   int   sv_seen = 0;
   int   acc;

   qam_mod_ctrl dut (
      .clk(clk), .rst(rst), .mod_type(mod_type), .baud_rate(baud_rate),
      .filter_enable(filter_enable), .carrier_freq_set(carrier_freq_set),
      .cfg_load(cfg_load), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .sym_data(sym_data), .sym_valid(sym_valid),
      .sym_fill(sym_fill), .act_mod_type(act_mod_type), .act_baud(act_baud),
      .act_filter(act_filter), .act_freq(act_freq), .busy(busy),
      .cfg_pending(cfg_pending)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every strobe must match the head of the queue.
   always @(negedge clk) begin
      if (sym_valid === 1'b1) begin
         sv_seen++;
         if (sb.size() == 0) begin
            chk("sym_unexpected", 32'(sym_valid), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("sym_data", 32'(sym_data), 32'(mon_e.data));
            chk("sym_fill", 32'(sym_fill), 32'(mon_e.fill));
            chk("sym_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   task automatic push(input logic [3:0] d, input logic f);
      exp_t e;
      e.data = d;
      e.fill = f;
      e.cyc  = nxt;
      sb.push_back(e);
      last_cyc = nxt;
      nxt = nxt + div;
   endtask

   task automatic push_fills(input int n);
      for (int i = 0; i < n; i++) push(4'd0, 1'b1);
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic send(input logic [7:0] b, output int acc_cyc);
      in_data  = b;
      in_valid = 1'b1;
      for (int i = 0; i < 20000; i++) begin
         if (in_ready === 1'b1) break;
         @(negedge clk);
      end
      chk("send_ready", 32'(in_ready), 32'd1);
      acc_cyc = cyc + 1;
      @(negedge clk);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 40000; i++) begin
         @(negedge clk);
         if (busy === 1'b0) break;
      end
      chk(tag, 32'(cyc), 32'(last_cyc));
   endtask

   task automatic wait_empty(input string tag);
      for (int i = 0; i < 25000; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic chk_reset_vals();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_sym_data", 32'(sym_data), 32'd0);
      chk("rst_sym_valid", 32'(sym_valid), 32'd0);
      chk("rst_sym_fill", 32'(sym_fill), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cfg_pending", 32'(cfg_pending), 32'd0);
      chk("rst_act_mod", 32'(act_mod_type), 32'd0);
      chk("rst_act_baud", 32'(act_baud), 32'd3);
      chk("rst_act_filter", 32'(act_filter), 32'd0);
      chk("rst_act_freq", 32'(act_freq), 32'd0);
   endtask

   initial begin
      rst = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; in_data = 8'd0;
      mod_type = 1'b0; baud_rate = 2'b00; filter_enable = 1'b0; carrier_freq_set = 16'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_vals();

      // 16QAM at 9600 baud, one byte, then a mid-burst config change.
      mod_type = 1'b1; baud_rate = 2'b11; filter_enable = 1'b1; carrier_freq_set = 16'd1000;
      cfg_load = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
      chk("idle_cfg_mod", 32'(act_mod_type), 32'd1);
      chk("idle_cfg_filter", 32'(act_filter), 32'd1);
      chk("idle_cfg_freq", 32'(act_freq), 32'd1000);
      div = 1152;
      send(8'hA5, acc);
      in_valid = 1'b0;
      nxt = acc + 1;
      push(4'hA, 1'b0); push(4'h5, 1'b0); push_fills(4);
      repeat (2) @(negedge clk);
      mod_type = 1'b0; baud_rate = 2'b10; filter_enable = 1'b0; carrier_freq_set = 16'd50000;
      cfg_load = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
      chk("run_cfg_pending", 32'(cfg_pending), 32'd1);
      chk("run_act_mod_frozen", 32'(act_mod_type), 32'd1);
      chk("run_act_freq_frozen", 32'(act_freq), 32'd1000);
      chk("run_busy", 32'(busy), 32'd1);
      wait_idle("t1_idle_cycle");
      chk("idle_act_freq", 32'(act_freq), 32'd50000);
      chk("idle_act_mod", 32'(act_mod_type), 32'd0);
      chk("idle_act_baud", 32'(act_baud), 32'd2);
      chk("idle_cfg_pending", 32'(cfg_pending), 32'd0);
      @(negedge clk);
      chk("t1_drained", 32'(sb.size()), 32'd0);

      // QPSK at 4800 baud: 0xB4 -> 2,3,1,0 then four fills.
      div = 2304;
      send(8'hB4, acc);
      in_valid = 1'b0;
      nxt = acc + 1;
      push(4'd2, 1'b0); push(4'd3, 1'b0); push(4'd1, 1'b0); push(4'd0, 1'b0); push_fills(4);
      wait_idle("t2_idle_cycle");
      @(negedge clk);
      chk("t2_drained", 32'(sb.size()), 32'd0);

      // Back-to-back 16QAM bytes; config load coincides with the first handshake.
      mod_type = 1'b1; baud_rate = 2'b11; filter_enable = 1'b1; carrier_freq_set = 16'd2000;
      cfg_load = 1'b1;
      div = 1152;
      send(8'h12, acc);
      cfg_load = 1'b0;
      chk("t3_ready_low_hold_full", 32'(in_ready), 32'd0);
      chk("t3_cfg_applied", 32'(act_mod_type), 32'd1);
      nxt = acc + 1;
      push(4'd1, 1'b0); push(4'd2, 1'b0);
      send(8'h34, acc);
      push(4'd3, 1'b0); push(4'd4, 1'b0);
      send(8'h56, acc);
      in_valid = 1'b0;
      push(4'd5, 1'b0); push(4'd6, 1'b0); push_fills(4);
      wait_idle("t3_idle_cycle");
      @(negedge clk);
      chk("t3_drained", 32'(sb.size()), 32'd0);

      // Underrun recovery: second byte after two fill ticks.
      send(8'h9C, acc);
      in_valid = 1'b0;
      nxt = acc + 1;
      push(4'h9, 1'b0); push(4'hC, 1'b0); push_fills(2);
      wait_empty("t5_two_fills");
      send(8'h3E, acc);
      in_valid = 1'b0;
      chk("t5_busy_through_underrun", 32'(busy), 32'd1);
      push(4'h3, 1'b0); push(4'hE, 1'b0); push_fills(4);
      wait_idle("t5_idle_cycle");
      @(negedge clk);
      chk("t5_drained", 32'(sb.size()), 32'd0);

      // QPSK at 1200 baud, reset after two of four symbols.
      mod_type = 1'b0; baud_rate = 2'b00; filter_enable = 1'b0; carrier_freq_set = 16'd3000;
      cfg_load = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
      div = 9216;
      send(8'hA5, acc);
      in_valid = 1'b0;
      nxt = acc + 1;
      push(4'd2, 1'b0); push(4'd2, 1'b0);
      wait_empty("t6_two_syms");
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;
      sv_seen = 0;
      repeat (9300) @(negedge clk);
      chk("t6_no_sym_after_rst", 32'(sv_seen), 32'd0);
      chk("t6_ready_after_rst", 32'(in_ready), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
